// File: rtl/corescore_uart_tx_fifo.sv
// UART transmitter fed by a power-of-two FIFO; frames leave back-to-back with no idle gap.
// Line is registered one cycle behind the FSM; o_ready drops only when the FIFO holds fifo_depth words.
module corescore_uart_tx_fifo #(
   parameter int clk_freq_hz = 50000000,
   parameter int baud_rate   = 1000000,
   parameter int data_bits   = 8,
   parameter int parity      = 0,
   parameter int stop_bits   = 1,
   parameter int fifo_depth  = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [data_bits-1:0]        i_data,
   input  logic                        i_valid,
   output logic                        o_ready,
   output logic                        o_uart_tx,
   output logic                        o_busy,
   output logic [$clog2(fifo_depth):0] o_fifo_count
);

   localparam int DIV = clk_freq_hz / baud_rate;
   localparam int CW  = $clog2(DIV) + 1;
   localparam int AW  = $clog2(fifo_depth);
   localparam int NW  = $clog2(fifo_depth) + 1;
   localparam int BW  = 4;
   localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

   if (data_bits < 5 || data_bits > 9) begin : g_bad_data_bits
      $error("data_bits must be 5..9");
   end
   if (stop_bits != 1 && stop_bits != 2) begin : g_bad_stop_bits
      $error("stop_bits must be 1 or 2");
   end
   if (DIV < 2) begin : g_bad_div
      $error("clk_freq_hz/baud_rate must be >= 2");
   end
   if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
      $error("fifo_depth must be a power of two >= 2");
   end
   if (parity < 0 || parity > 2) begin : g_bad_parity
      $error("parity must be 0, 1 or 2");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [data_bits-1:0] mem_q [fifo_depth];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [NW-1:0]        count_q, count_d;
   state_t               state_q, state_d;
   logic [CW-1:0]        div_q, div_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [data_bits-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 push, pop, tick;
   logic [data_bits-1:0] head;

   assign o_ready      = (count_q != NW'(fifo_depth));
   assign push         = i_valid & o_ready;
   assign head         = mem_q[rd_ptr_q];
   assign tick         = (div_q == '0);
   assign o_uart_tx    = tx_q;
   assign o_busy       = (state_q != S_IDLE) || (count_q != '0);
   assign o_fifo_count = count_q;

   always_comb begin
      state_d = state_q;
      div_d   = tick ? DIV_M1 : div_q - CW'(1);
      bit_d   = bit_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      pop     = 1'b0;
      tx_d    = 1'b1;
      case (state_q)
         S_IDLE: begin
            div_d = DIV_M1;
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            tx_d = 1'b0;
            if (tick) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            tx_d = shreg_q[0];
            if (tick) begin
               if (bit_q == BW'(data_bits - 1)) begin
                  bit_d   = '0;
                  state_d = (parity != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d   = bit_q + BW'(1);
                  shreg_d = shreg_q >> 1;
               end
            end
         end
         S_PARITY: begin
            tx_d = par_q;
            if (tick) begin
               state_d = S_STOP;
               bit_d   = '0;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (tick) begin
               if (bit_q == BW'(stop_bits - 1)) begin
                  // chain straight into the next start bit when a word is waiting
                  if (count_q != '0) begin
                     pop     = 1'b1;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (pop) begin
         shreg_d = head;
         par_d   = (parity == 1) ? ~(^head) : (^head);
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + NW'(1);
         2'b01:   count_d = count_q - NW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q] <= i_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         div_q    <= DIV_M1;
         bit_q    <= '0;
         shreg_q  <= '0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         par_q    <= par_d;
         tx_q     <= tx_d;
         wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
         rd_ptr_q <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_corescore_uart_tx_fifo.sv
// Four configurations (8N1, 8O2, 8E1, 5N1 at DIV=8) checked against frames built from the bit rules.
module tb_corescore_uart_tx_fifo;

   localparam int DIV = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [8:0] dat  [4];
   logic       vld  [4];
   logic       rdy  [4];
   logic       tx   [4];
   logic       busy [4];
   logic [2:0] cnt  [4];

   int n_vec = 0;
   int n_err = 0;
   int waited, cnt_seen;
   logic [7:0] sb_q [$];
   logic [8:0] w2 [6];

   always #5 clk = ~clk;

   corescore_uart_tx_fifo #(.clk_freq_hz(8), .baud_rate(1), .data_bits(8), .parity(0),
                            .stop_bits(1), .fifo_depth(4)) u0 (
      .i_clk(clk), .i_rst(rst), .i_data(dat[0][7:0]), .i_valid(vld[0]), .o_ready(rdy[0]),
      .o_uart_tx(tx[0]), .o_busy(busy[0]), .o_fifo_count(cnt[0]));
   corescore_uart_tx_fifo #(.clk_freq_hz(8), .baud_rate(1), .data_bits(8), .parity(1),
                            .stop_bits(2), .fifo_depth(4)) u1 (
      .i_clk(clk), .i_rst(rst), .i_data(dat[1][7:0]), .i_valid(vld[1]), .o_ready(rdy[1]),
      .o_uart_tx(tx[1]), .o_busy(busy[1]), .o_fifo_count(cnt[1]));
   corescore_uart_tx_fifo #(.clk_freq_hz(8), .baud_rate(1), .data_bits(8), .parity(2),
                            .stop_bits(1), .fifo_depth(4)) u2 (
      .i_clk(clk), .i_rst(rst), .i_data(dat[2][7:0]), .i_valid(vld[2]), .o_ready(rdy[2]),
      .o_uart_tx(tx[2]), .o_busy(busy[2]), .o_fifo_count(cnt[2]));
   corescore_uart_tx_fifo #(.clk_freq_hz(8), .baud_rate(1), .data_bits(5), .parity(0),
                            .stop_bits(1), .fifo_depth(4)) u3 (
      .i_clk(clk), .i_rst(rst), .i_data(dat[3][4:0]), .i_valid(vld[3]), .o_ready(rdy[3]),
      .o_uart_tx(tx[3]), .o_busy(busy[3]), .o_fifo_count(cnt[3]));

   function automatic int db_of(input int k);
      return (k == 3) ? 5 : 8;
   endfunction
   function automatic int par_of(input int k);
      return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
   endfunction
   function automatic int sb_of(input int k);
      return (k == 1) ? 2 : 1;
   endfunction
   function automatic int frame_len(input int k);
      return (1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + sb_of(k)) * DIV;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push(input int k, input logic [8:0] w, input int budget,
                       output int n_wait, output int c_seen);
      dat[k] = w;
      vld[k] = 1'b1;
      n_wait = 0;
      while (rdy[k] !== 1'b1 && n_wait < budget) begin
         @(negedge clk);
         n_wait++;
      end
      chk($sformatf("u%0d_push_rdy", k), 32'(rdy[k]), 1);
      c_seen = int'(cnt[k]);
      @(negedge clk);
      vld[k] = 1'b0;
      dat[k] = 9'($urandom);
   endtask

   task automatic wait_start(input int k, input int budget);
      int n = 0;
      while (tx[k] !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("u%0d_start_seen", k), 32'(tx[k]), 0);
   endtask

   // Current sample is the first start-bit sample; ends on the last stop-bit sample.
   task automatic frame_body(input int k, input logic [8:0] w);
      int nd   = db_of(k);
      int np   = (par_of(k) != 0) ? 1 : 0;
      int ns   = sb_of(k);
      int ones = $countones(w & 9'((1 << nd) - 1));
      for (int i = 0; i < 1 + nd + np + ns; i++) begin
         int e;
         if (i == 0)                      e = 0;
         else if (i <= nd)                e = int'(w[i-1]);
         else if (np == 1 && i == nd + 1) e = (par_of(k) == 1) ? ((ones % 2 == 0) ? 1 : 0)
                                                               : ((ones % 2 == 1) ? 1 : 0);
         else                             e = 1;
         for (int j = 0; j < DIV; j++) begin
            if (i != 0 || j != 0) @(negedge clk);
            chk($sformatf("u%0d_bit%0d", k, i), 32'(tx[k]), e);
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         vld[k] = 1'b0;
         dat[k] = '0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("u%0d_rst_tx", k),   32'(tx[k]), 1);
         chk($sformatf("u%0d_rst_rdy", k),  32'(rdy[k]), 1);
         chk($sformatf("u%0d_rst_busy", k), 32'(busy[k]), 0);
         chk($sformatf("u%0d_rst_cnt", k),  32'(cnt[k]), 0);
      end
      rst = 1'b0;
      @(negedge clk);

      // single 0xA5 frame and its two-edge latency
      push(0, 9'h0A5, 10, waited, cnt_seen);
      chk("t1_cnt_after_push", 32'(cnt[0]), 1);
      chk("t1_busy", 32'(busy[0]), 1);
      chk("t1_tx_edge1", 32'(tx[0]), 1);
      @(negedge clk);
      chk("t1_tx_edge2", 32'(tx[0]), 1);
      chk("t1_cnt_popped", 32'(cnt[0]), 0);
      @(negedge clk);
      chk("t1_tx_low", 32'(tx[0]), 0);
      frame_body(0, 9'h0A5);
      @(negedge clk);
      chk("t1_idle_tx", 32'(tx[0]), 1);
      chk("t1_idle_busy", 32'(busy[0]), 0);

      // six back-to-back words; the sixth is held through the full-FIFO pop cycle
      for (int i = 0; i < 6; i++) w2[i] = 9'($urandom_range(0, 255));
      fork
         begin : t2_push
            for (int i = 0; i < 5; i++) begin
               push(0, w2[i], 10, waited, cnt_seen);
               chk("t2_rdy", 32'(rdy[0]), (i == 4) ? 0 : 1);
            end
            chk("t2_cnt_full", 32'(cnt[0]), 4);
            push(0, w2[5], 300, waited, cnt_seen);
            // 5th word lands 3 edges into frame 1; pop is refused-push edge at frame end
            chk("t4_wait_cycles", waited, frame_len(0) - 3);
            chk("t4_cnt_at_accept", cnt_seen, 3);
            chk("t4_cnt_refilled", 32'(cnt[0]), 4);
            chk("t4_rdy_refilled", 32'(rdy[0]), 0);
         end
         begin : t2_line
            wait_start(0, 20);
            frame_body(0, w2[0]);
            for (int i = 1; i < 6; i++) begin
               @(negedge clk);
               frame_body(0, w2[i]);
            end
         end
      join
      @(negedge clk);
      chk("t2_idle_busy", 32'(busy[0]), 0);

      // parity odd/even, two stop bits; second frame must follow with no gap
      for (int k = 1; k <= 2; k++) begin
         push(k, 9'h003, 10, waited, cnt_seen);
         push(k, 9'h007, 10, waited, cnt_seen);
         wait_start(k, 20);
         frame_body(k, 9'h003);
         @(negedge clk);
         frame_body(k, 9'h007);
         @(negedge clk);
         chk($sformatf("u%0d_idle_tx", k), 32'(tx[k]), 1);
      end

      // 5-bit words
      push(3, 9'h1FF, 10, waited, cnt_seen);
      push(3, 9'h00A, 10, waited, cnt_seen);
      wait_start(3, 20);
      frame_body(3, 9'h01F);
      @(negedge clk);
      frame_body(3, 9'h00A);
      @(negedge clk);
      chk("t6_idle_busy", 32'(busy[3]), 0);

      // reset in the middle of the data bits with words still queued
      push(0, 9'h0F0, 10, waited, cnt_seen);
      push(0, 9'h055, 10, waited, cnt_seen);
      push(0, 9'h0AA, 10, waited, cnt_seen);
      wait_start(0, 20);
      repeat (DIV + 2 * DIV + 3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_tx", 32'(tx[0]), 1);
      chk("t5_cnt", 32'(cnt[0]), 0);
      chk("t5_busy", 32'(busy[0]), 0);
      chk("t5_rdy", 32'(rdy[0]), 1);
      rst = 1'b0;
      begin
         int lows = 0;
         for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) lows++;
         end
         chk("t5_no_tail", lows, 0);
      end

      // random words with random idle gaps against a scoreboard
      fork
         begin : rnd_push
            for (int i = 0; i < 20; i++) begin
               logic [7:0] w;
               int gap = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 120) : $urandom_range(0, 3);
               repeat (gap) @(negedge clk);
               w = 8'($urandom);
               push(0, {1'b0, w}, 400, waited, cnt_seen);
               sb_q.push_back(w);
            end
         end
         begin : rnd_line
            for (int i = 0; i < 20; i++) begin
               logic [7:0] w;
               wait_start(0, 1000);
               chk("rnd_sb_nonempty", 32'(sb_q.size() > 0), 1);
               w = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
               frame_body(0, {1'b0, w});
            end
         end
      join
      chk("rnd_sb_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
